// File: rtl/sc_4b_pkg.sv
// Shared constants and types for the 4-bit synchronous counter slice.
package sc_pkg;

    localparam int SC_WIDTH = 4;

    typedef logic [SC_WIDTH-1:0] count_t;

    localparam count_t SC_MAX  = '1;
    localparam count_t SC_ZERO = '0;

endpackage : sc_pkg

// File: rtl/sc_4b_if.sv
// Counter control/status bundle.
//
// Handshake: there is no valid/ready pair here. cten and prs are level
// controls sampled on every rising clock edge; out is the registered count
// and tc is a combinational flag (cten AND out==all-ones) valid whenever
// cten and out are stable.
interface sc_4b_if
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
);
    logic             cten;
    logic             prs;
    logic [WIDTH-1:0] out;
    logic             tc;

    modport master (
        output cten,
        output prs,
        input  out,
        input  tc
    );

    modport slave (
        input  cten,
        input  prs,
        output out,
        output tc
    );
endinterface : sc_4b_if

// File: rtl/sc_4b_bit_cell.sv
// One counter bit: a single flop with synchronous clear, preset and toggle.
module sc_bit_cell (
    input  logic clk,
    input  logic clr,
    input  logic prs_i,
    input  logic tgl_i,
    output logic q_o
);
    logic q_q;
    logic q_d;

    // Next value: preset beats toggle; clear is applied in the flop itself.
    always_comb begin
        q_d = q_q;
        if (prs_i) begin
            q_d = 1'b1;
        end else if (tgl_i) begin
            q_d = ~q_q;
        end
    end

    // Bit register with synchronous active-low clear taking top priority.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule : sc_bit_cell

// File: rtl/sc_4b.sv
// 4-bit synchronous up-counter with preset, built from per-bit toggle cells.
// Each bit toggles when cten is high and every lower bit is one, so all
// carries are resolved in parallel from the current count.
module sc_4b
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic          clk,
    input  logic          clr,
    sc_4b_if.slave        bus
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] tgl;

    // Per-bit toggle enables and bit cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign tgl[i] = bus.cten;
        end else begin : g_upper
            assign tgl[i] = bus.cten & (&cnt[i-1:0]);
        end

        sc_bit_cell u_cell (
            .clk   (clk),
            .clr   (clr),
            .prs_i (bus.prs),
            .tgl_i (tgl[i]),
            .q_o   (cnt[i])
        );
    end

    assign bus.out = cnt;
    // Terminal count gated by cten so cascaded blocks only ripple when enabled.
    assign bus.tc  = bus.cten & (&cnt);
endmodule : sc_4b

// File: tb/tb_sc_4b.sv
// Directed and randomized bench for sc_4b against a small arithmetic model.
module tb_sc_4b;
    import sc_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;

    sc_4b_if #(.WIDTH(SC_WIDTH)) bus ();

    sc_4b #(.WIDTH(SC_WIDTH)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one edge's inputs, advance the model, compare out/tc just after the edge.
    task automatic tick(input logic c, input logic p, input logic e, input string tag);
        clr      = c;
        bus.prs  = p;
        bus.cten = e;
        @(posedge clk);
        if (!c)      exp_cnt = 0;
        else if (p)  exp_cnt = 15;
        else if (e)  exp_cnt = (exp_cnt + 1) % 16;
        #1;
        check({tag, ".out"}, {4'h0, bus.out}, 8'(exp_cnt));
        check({tag, ".tc"},  {7'h0, bus.tc},  {7'h0, (e && exp_cnt == 15)});
    endtask

    int tc_pulses;
    int run_len;
    int max_run;

    initial begin
        bus.cten = 1'b0;
        bus.prs  = 1'b0;

        // Reset and count
        tick(1'b0, 1'b0, 1'b0, "reset");
        check("reset_zero", {4'h0, bus.out}, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, "count5");
        check("count5_val", {4'h0, bus.out}, 8'h05);

        // Wrap
        tick(1'b0, 1'b0, 1'b0, "wrap_rst");
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 1'b1, "wrap_up");
        check("wrap_15", {4'h0, bus.out}, {4'h0, SC_MAX});
        check("wrap_tc", {7'h0, bus.tc}, 8'h01);
        tick(1'b1, 1'b0, 1'b1, "wrap_edge");
        check("wrap_0", {4'h0, bus.out}, {4'h0, SC_ZERO});

        // Hold
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b1, "to7");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, "hold7");
        check("hold7_val", {4'h0, bus.out}, 8'h07);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, "to15");
        tick(1'b1, 1'b0, 1'b0, "hold15");
        check("hold15_tc", {7'h0, bus.tc}, 8'h00);

        // Preset
        tick(1'b0, 1'b0, 1'b0, "pre_rst");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, "to3");
        tick(1'b1, 1'b1, 1'b1, "preset");
        check("preset_val", {4'h0, bus.out}, 8'h0f);
        check("preset_tc", {7'h0, bus.tc}, 8'h01);
        tick(1'b1, 1'b0, 1'b1, "post_preset");
        check("post_preset_val", {4'h0, bus.out}, 8'h00);

        // tc follows cten combinationally with no edge in between
        tick(1'b1, 1'b1, 1'b0, "preset_idle");
        bus.cten = 1'b1;
        #1;
        check("tc_comb_on", {7'h0, bus.tc}, 8'h01);
        bus.cten = 1'b0;
        #1;
        check("tc_comb_off", {7'h0, bus.tc}, 8'h00);

        // Priority
        tick(1'b0, 1'b1, 1'b1, "clr_beats_prs");
        check("clr_beats_prs_val", {4'h0, bus.out}, 8'h00);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b1, "to9");
        tick(1'b0, 1'b0, 1'b1, "mid_clr");
        check("mid_clr_val", {4'h0, bus.out}, 8'h00);
        tick(1'b1, 1'b0, 1'b1, "resume");
        check("resume_val", {4'h0, bus.out}, 8'h01);

        // Pulses between edges are ignored
        #1;
        bus.prs  = 1'b1;
        bus.cten = 1'b1;
        clr      = 1'b0;
        #2;
        bus.prs  = 1'b0;
        bus.cten = 1'b0;
        clr      = 1'b1;
        tick(1'b1, 1'b0, 1'b0, "glitch");
        check("glitch_val", {4'h0, bus.out}, 8'h01);

        // Long run
        tick(1'b0, 1'b0, 1'b0, "long_rst");
        tc_pulses = 0;
        run_len   = 0;
        max_run   = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b0, 1'b1, "long");
            if (bus.tc === 1'b1) begin
                if (run_len == 0) tc_pulses++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        check("long_val", {4'h0, bus.out}, 8'h04);
        check("long_pulses", 8'(tc_pulses), 8'd6);
        check("long_width", 8'(max_run), 8'd1);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            tick(logic'($urandom_range(0, 15) != 0),
                 logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule : tb_sc_4b

// File: doc/sc_4b.md
SC_4B -- requirements
Module: sc_4b

Interface
REQ-001 Parameter WIDTH, default 4; counter width in bits. The only supported and verified value is 4.
REQ-002 Port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 Port clr, input, 1 bit; reset is synchronous and active-low.
REQ-004 Port cten, input, 1 bit; count enable, active-high.
REQ-005 Port prs, input, 1 bit; synchronous preset, active-high.
REQ-006 Port out, output, WIDTH bits; current count value, taken directly from registers.
REQ-007 Port tc, output, 1 bit; terminal-count flag, combinational.

Function
REQ-008 The block SHALL update out only on rising edges of clk, with no asynchronous paths into the state.
REQ-009 Edge priority SHALL be, highest first:
- clr==0 -> out<=0
- else prs==1 -> out<=4'hF (all ones)
- else cten==1 -> out<=out+1
- else out holds.
REQ-010 Increment SHALL be modulo 2^WIDTH, so 4'hF with cten=1 wraps to 4'h0 on the next edge, with no carry-out stored.
REQ-011 tc SHALL equal cten AND (out==4'hF), so tc=0 whenever cten=0. This allows ripple-enable cascading of multiple blocks.
REQ-012 tc SHALL be glitch-tolerant combinational logic, with no extra register stage.
REQ-013 Count latency SHALL be exactly one clock: a value change appears on out after the same rising edge that samples cten=1.
REQ-014 When prs=1 and cten=1 are both high at one edge, the preset wins, out becomes 4'hF, and tc asserts immediately while cten stays 1.
REQ-015 When clr=0 and prs=1 are both active at one edge, the clear wins and out becomes 0.
REQ-016 Inputs SHALL be sampled only at clock edges; pulses between edges have no effect.

Reset
REQ-017 While clr=0 is sampled at a rising edge, out SHALL become 4'h0. tc is then 0, since out is not 4'hF.
REQ-018 A clear in the middle of counting SHALL take effect at the next edge and override any count or preset.
REQ-019 Counting SHALL resume from 0 on the first edge after clr returns to 1 with cten=1, giving out=1 after that edge.
REQ-020 Before the first clearing edge, the state is undefined. The bench SHALL apply clr=0 for at least one edge before checking outputs.

Structure
REQ-021 A shared package sc_pkg SHALL hold:
- the constant SC_WIDTH=4
- the derived constants SC_MAX=4'hF and SC_ZERO=4'h0
- a typedef count_t for the WIDTH-bit logic vector.
REQ-022 The counter SHALL be built from WIDTH instances of one sub-module, sc_bit_cell. Each cell holds a single D flip-flop with synchronous clear/preset/toggle, and the toggle is enabled by cten AND all lower bits being 1 (synchronous carry-lookahead).
REQ-023 The top level SHALL generate the per-bit toggle enables and tc, and SHALL instantiate the cells with a generate loop.

Verification
REQ-024 Reset and count: clr=0 for 1 edge, then clr=1, cten=1 for 5 edges -> out=0 after the reset edge, then out=5, with tc=0 throughout.
REQ-025 Wrap: count from 0 with cten=1 for 15 edges -> out=15 and tc=1; one more edge -> out=0 and tc=0.
REQ-026 Hold: at out=7, set cten=0 for 3 edges -> out stays 7 and tc=0; at out=15 with cten=0 -> tc=0.
REQ-027 Preset: at out=3 with cten=1, prs=1 for 1 edge -> out=15 and tc=1; then prs=0 -> out=0 after the next edge.
REQ-028 Priority: clr=0, prs=1, cten=1 at one edge -> out=0; clr=0 asserted at out=9 mid-count -> out=0 on that edge, then out=1 on the following edge.
REQ-029 Long run: cten=1 for 100 edges after reset -> out=100 mod 16=4, and tc pulses exactly 6 times, each pulse one cycle wide.
